// File: rtl/primitive_cache.sv
// primitive_cache: per-triangle AABB word store for the primitive-unit write
// channel, with a second enable/valid read channel for the rasteriser.
// Each entry carries a valid bit so readers can spot slots not written since
// the last clear. A write wins over a simultaneous read; the read waits.
// Optional macro PRIMITIVE_CACHE_STATS_EN adds saturating access counters.
module primitive_cache #(
  parameter int DEPTH = 256
) (
  input  logic                        aClock,
  input  logic                        aReset,
  input  logic [31:0]                 aWriteAddress,
  input  logic [31:0]                 aWriteData,
  input  logic                        aWriteEnable,
  output logic                        aWriteValid,
  input  logic [31:0]                 aReadAddress,
  input  logic                        aReadEnable,
  output logic [31:0]                 anOutReadData,
  output logic                        anOutReadValid,
  output logic                        anOutReadMiss,
  input  logic                        aClear,
  output logic [$clog2(DEPTH):0]      anOutEntryCount,
`ifdef PRIMITIVE_CACHE_STATS_EN
  output logic [15:0]                 anOutWriteCount,
  output logic [15:0]                 anOutReadCount,
`endif
  output logic                        anOutError
);

  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, WRITE_ACK, READ_ACK} state_t;

  state_t              state_q, state_d;
  logic                wvalid_q, wvalid_d;
  logic                rvalid_q, rvalid_d;
  logic                miss_q, miss_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
`ifdef PRIMITIVE_CACHE_STATS_EN
  logic [15:0]         wcnt_q, wcnt_d;
  logic [15:0]         rcnt_q, rcnt_d;
`endif

  logic [31:0]         mem [DEPTH];
  logic                mem_we;

  logic [ADDR_W-1:0]   w_idx, r_idx;
  logic                w_in, r_in;

  assign w_idx = aWriteAddress[ADDR_W-1:0];
  assign r_idx = aReadAddress[ADDR_W-1:0];
  assign w_in  = aWriteAddress < DEPTH_W;
  assign r_in  = aReadAddress  < DEPTH_W;

  // Next-state: clear is folded in first so a same-edge write lands on top of it.
  always_comb begin
    state_d  = state_q;
    wvalid_d = wvalid_q;
    rvalid_d = rvalid_q;
    miss_d   = miss_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    valid_d  = aClear ? '0   : valid_q;
    count_d  = aClear ? '0   : count_q;
    err_d    = aClear ? 1'b0 : err_q;
`ifdef PRIMITIVE_CACHE_STATS_EN
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (aWriteEnable) begin
          wvalid_d = 1'b1;
          state_d  = WRITE_ACK;
`ifdef PRIMITIVE_CACHE_STATS_EN
          if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
`endif
          if (w_in) begin
            mem_we = 1'b1;
            if (!valid_d[w_idx]) count_d = count_d + CNT_ONE;
            valid_d[w_idx] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (aReadEnable) begin
          rvalid_d = 1'b1;
          state_d  = READ_ACK;
`ifdef PRIMITIVE_CACHE_STATS_EN
          if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
`endif
          if (r_in && valid_q[r_idx]) begin
            rdata_d = mem[r_idx];
            miss_d  = 1'b0;
          end else begin
            rdata_d = '0;
            miss_d  = 1'b1;
          end
          if (!r_in) err_d = 1'b1;
        end
      end
      default: begin
        // Ack cycle: requests still asserted here are deliberately ignored.
        wvalid_d = 1'b0;
        rvalid_d = 1'b0;
        miss_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM and all registered outputs.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      state_q  <= IDLE;
      wvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      miss_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= '0;
      count_q  <= '0;
`ifdef PRIMITIVE_CACHE_STATS_EN
      wcnt_q   <= '0;
      rcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wvalid_q <= wvalid_d;
      rvalid_q <= rvalid_d;
      miss_q   <= miss_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
`ifdef PRIMITIVE_CACHE_STATS_EN
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  // Storage array; contents survive reset, validity is tracked separately.
  always_ff @(posedge aClock) begin
    if (mem_we) mem[w_idx] <= aWriteData;
  end

  assign aWriteValid     = wvalid_q;
  assign anOutReadValid  = rvalid_q;
  assign anOutReadMiss   = miss_q;
  assign anOutReadData   = rdata_q;
  assign anOutError      = err_q;
  assign anOutEntryCount = count_q;
`ifdef PRIMITIVE_CACHE_STATS_EN
  assign anOutWriteCount = wcnt_q;
  assign anOutReadCount  = rcnt_q;
`endif

endmodule

// File: tb/tb_primitive_cache.sv
// Bench for primitive_cache: directed vector table, hand-written corner
// sequences, then randomized traffic against an associative-array model.
module tb_primitive_cache;

  localparam int DEPTH = 256;

  logic        aClock = 1'b0;
  logic        aReset;
  logic [31:0] aWriteAddress, aWriteData, aReadAddress;
  logic        aWriteEnable, aReadEnable, aClear;
  logic        aWriteValid, anOutReadValid, anOutReadMiss, anOutError;
  logic [31:0] anOutReadData;
  logic [8:0]  anOutEntryCount;
`ifdef PRIMITIVE_CACHE_STATS_EN
  logic [15:0] anOutWriteCount, anOutReadCount;
`endif

  primitive_cache #(.DEPTH(DEPTH)) dut (
    .aClock(aClock), .aReset(aReset),
    .aWriteAddress(aWriteAddress), .aWriteData(aWriteData),
    .aWriteEnable(aWriteEnable), .aWriteValid(aWriteValid),
    .aReadAddress(aReadAddress), .aReadEnable(aReadEnable),
    .anOutReadData(anOutReadData), .anOutReadValid(anOutReadValid),
    .anOutReadMiss(anOutReadMiss), .aClear(aClear),
    .anOutEntryCount(anOutEntryCount),
`ifdef PRIMITIVE_CACHE_STATS_EN
    .anOutWriteCount(anOutWriteCount), .anOutReadCount(anOutReadCount),
`endif
    .anOutError(anOutError)
  );

  always #5 aClock = ~aClock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: which words hold which data, and the sticky error.
  logic [31:0] m_mem [int];
  bit          m_err;
  int          m_wr_n, m_rd_n;

  function automatic int m_count();
    return m_mem.size();
  endfunction

  task automatic do_reset();
    aReset = 1'b1;
    aWriteEnable = 0; aReadEnable = 0; aClear = 0;
    aWriteAddress = 0; aWriteData = 0; aReadAddress = 0;
    #12;
    aReset = 1'b0;
    m_mem.delete(); m_err = 0; m_wr_n = 0; m_rd_n = 0;
    @(negedge aClock);
  endtask

  // Write with enable held until ack; checks one-cycle latency and single pulse.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit clr);
    int n;
    @(negedge aClock);
    aWriteAddress = addr; aWriteData = data; aWriteEnable = 1; aClear = clr;
    n = 0;
    do begin
      @(negedge aClock);
      aClear = 0;
      n++;
    end while (!aWriteValid && n < 20);
    chk("wr_latency", n, 1);
    aWriteEnable = 0;
    @(negedge aClock);
    chk("wr_single_pulse", {31'b0, aWriteValid}, 0);
    if (clr) m_mem.delete();
    if (clr) m_err = 0;
    if (addr < DEPTH) m_mem[int'(addr)] = data; else m_err = 1;
    m_wr_n++;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output bit miss);
    int n;
    @(negedge aClock);
    aReadAddress = addr; aReadEnable = 1;
    n = 0;
    do begin
      @(negedge aClock);
      n++;
    end while (!anOutReadValid && n < 20);
    chk("rd_latency", n, 1);
    data = anOutReadData; miss = anOutReadMiss;
    aReadEnable = 0;
    @(negedge aClock);
    chk("rd_single_pulse", {31'b0, anOutReadValid}, 0);
    if (addr >= DEPTH) m_err = 1;
    m_rd_n++;
  endtask

  task automatic pulse_clear();
    @(negedge aClock);
    aClear = 1;
    @(negedge aClock);
    aClear = 0;
    m_mem.delete(); m_err = 0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    bit          exp_miss;
    int          exp_count;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] d;
    bit          mi;
    int          n;

    vecs[0] = '{1, 32'd5,   32'hDEAD_BEEF, 0,             0, 1, 0};
    vecs[1] = '{0, 32'd5,   0,             32'hDEAD_BEEF, 0, 1, 0};
    vecs[2] = '{0, 32'd7,   0,             0,             1, 1, 0};
    vecs[3] = '{1, 32'd255, 32'h0000_00AA, 0,             0, 2, 0};
    vecs[4] = '{0, 32'd255, 0,             32'h0000_00AA, 0, 2, 0};
    vecs[5] = '{1, 32'd256, 32'h1111_1111, 0,             0, 2, 1};
    vecs[6] = '{0, 32'h8000_0005, 0,       0,             1, 2, 1};
    vecs[7] = '{1, 32'd5,   32'h1234_5678, 0,             0, 2, 1};

    do_reset();
    chk("rst_wvalid", {31'b0, aWriteValid}, 0);
    chk("rst_rvalid", {31'b0, anOutReadValid}, 0);
    chk("rst_miss",   {31'b0, anOutReadMiss}, 0);
    chk("rst_err",    {31'b0, anOutError}, 0);
    chk("rst_rdata",  anOutReadData, 0);
    chk("rst_count",  {23'b0, anOutEntryCount}, 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data, 0);
      end else begin
        rd(vecs[i].addr, d, mi);
        chk("vec_rdata", d, vecs[i].exp_data);
        chk("vec_miss", {31'b0, mi}, {31'b0, vecs[i].exp_miss});
      end
      chk("vec_count", {23'b0, anOutEntryCount}, vecs[i].exp_count);
      chk("vec_err", {31'b0, anOutError}, {31'b0, vecs[i].exp_err});
    end
    rd(32'd5, d, mi);
    chk("rewrite_data", d, 32'h1234_5678);

    // Clear drops error, count and validity.
    pulse_clear();
    chk("clr_err", {31'b0, anOutError}, 0);
    chk("clr_count", {23'b0, anOutEntryCount}, 0);
    rd(32'd5, d, mi);
    chk("clr_read_miss", {31'b0, mi}, 1);

    // Write and read raised together: write first, read two cycles later.
    @(negedge aClock);
    aWriteAddress = 3; aWriteData = 32'hCAFE_0003; aWriteEnable = 1;
    aReadAddress = 3; aReadEnable = 1;
    @(negedge aClock);
    chk("coll_wack", {31'b0, aWriteValid}, 1);
    chk("coll_rack_early", {31'b0, anOutReadValid}, 0);
    aWriteEnable = 0;
    @(negedge aClock);
    chk("coll_rack_gap", {31'b0, anOutReadValid}, 0);
    @(negedge aClock);
    chk("coll_rack", {31'b0, anOutReadValid}, 1);
    chk("coll_rdata", anOutReadData, 32'hCAFE_0003);
    chk("coll_miss", {31'b0, anOutReadMiss}, 0);
    aReadEnable = 0;
    @(negedge aClock);

    // Rewrite entry 9, then clear coincident with write to 1.
    pulse_clear();
    wr(32'd9, 32'd10, 0);
    chk("rw9_count_a", {23'b0, anOutEntryCount}, 1);
    wr(32'd9, 32'd10, 0);
    chk("rw9_count_b", {23'b0, anOutEntryCount}, 1);
    wr(32'd1, 32'h0000_0001, 1);
    chk("clrwr_count", {23'b0, anOutEntryCount}, 1);
    rd(32'd1, d, mi);
    chk("clrwr_e1_miss", {31'b0, mi}, 0);
    chk("clrwr_e1_data", d, 32'h0000_0001);
    rd(32'd9, d, mi);
    chk("clrwr_e9_miss", {31'b0, mi}, 1);

    // Reset while an ack is pending drops it.
    @(negedge aClock);
    aWriteAddress = 4; aWriteEnable = 1;
    @(negedge aClock);
    chk("mid_ack_before", {31'b0, aWriteValid}, 1);
    aReset = 1; aWriteEnable = 0;
    #1;
    chk("mid_ack_dropped", {31'b0, aWriteValid}, 0);
    chk("mid_count", {23'b0, anOutEntryCount}, 0);
    aReset = 0;

`ifdef PRIMITIVE_CACHE_STATS_EN
    do_reset();
    wr(1, 1, 0); wr(2, 2, 0); wr(300, 3, 0);
    rd(1, d, mi); rd(2, d, mi);
    chk("stat_wr", {16'b0, anOutWriteCount}, 3);
    chk("stat_rd", {16'b0, anOutReadCount}, 2);
    pulse_clear();
    chk("stat_wr_clr", {16'b0, anOutWriteCount}, 3);
    chk("stat_rd_clr", {16'b0, anOutReadCount}, 2);
    aReset = 1; #1;
    chk("stat_wr_rst", {16'b0, anOutWriteCount}, 0);
    chk("stat_rd_rst", {16'b0, anOutReadCount}, 0);
    aReset = 0;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      n = int'($urandom_range(0, 99));
      a = (n < 8) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 40));
      if (n < 3) begin
        pulse_clear();
      end else if (n < 50) begin
        wr(a, $urandom, 0);
      end else begin
        rd(a, d, mi);
        if (m_mem.exists(int'(a)) && a < DEPTH) begin
          chk("rand_miss", {31'b0, mi}, 0);
          chk("rand_data", d, m_mem[int'(a)]);
        end else begin
          chk("rand_miss", {31'b0, mi}, 1);
          chk("rand_data", d, 0);
        end
      end
      chk("rand_count", {23'b0, anOutEntryCount}, m_count());
      chk("rand_err", {31'b0, anOutError}, {31'b0, m_err});
    end
`ifdef PRIMITIVE_CACHE_STATS_EN
    chk("rand_stat_wr", {16'b0, anOutWriteCount}, m_wr_n);
    chk("rand_stat_rd", {16'b0, anOutReadCount}, m_rd_n);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
